// File: rtl/note_lane_if.sv
// Bus between the lane engine, its chart ROM, the key front-end and the display/score path.
// slave is the engine side; master is whatever drives keys, ticks and the ROM data.
interface note_lane_if #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned ROWS    = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned SCORE_W = 32,
    parameter int unsigned CNT_W   = 16
);
    logic                    tick;
    logic                    start;
    logic                    pause;
    logic [LANES-1:0]        key_hit;
    logic [ADDR_W-1:0]       chart_addr;
    logic [LANES-1:0]        chart_data;
    logic [ROWS*LANES-1:0]   field;
    logic [SCORE_W-1:0]      score;
    logic [CNT_W-1:0]        combo;
    logic [CNT_W-1:0]        misses;
    logic [1:0]              state;
    logic                    done;

    modport master (
        output tick, start, pause, key_hit, chart_data,
        input  chart_addr, field, score, combo, misses, state, done
    );

    modport slave (
        input  tick, start, pause, key_hit, chart_data,
        output chart_addr, field, score, combo, misses, state, done
    );
endinterface

// File: rtl/note_lane_engine.sv
// Scrolls chart rows from a synchronous ROM through a LANES x ROWS playfield,
// grades key hits in the bottom HIT_WIN rows and keeps score, combo and miss counters.
module note_lane_engine #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ROWS      = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned CHART_LEN = 1024,
    parameter int unsigned HIT_WIN   = 2,
    parameter int unsigned SCORE_W   = 32,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    note_lane_if.slave bus
);
    localparam int unsigned FW = ROWS * LANES;
    localparam int unsigned HW = $clog2(2 * LANES + 1);
    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(CHART_LEN);

    // PREFETCH reports as IDLE on the state output while the first ROM row is fetched.
    typedef enum logic [2:0] {S_IDLE, S_PREFETCH, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      field_q, field_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LANES-1:0]   nxt_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   combo_q, combo_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic [1:0]         code_q, code_d;
    logic               done_q;

    logic [FW-1:0]      cleared;
    logic [FW-1:0]      shifted;
    logic [LANES-1:0]   row_in;
    logic [LANES-1:0]   lost;
    logic               found;
    logic [HW-1:0]      hit_cnt;
    logic [HW-1:0]      pts;
    logic [HW-1:0]      lost_cnt;
    logic [SCORE_W:0]   score_sum;
    logic [CNT_W:0]     combo_sum;
    logic [CNT_W:0]     miss_sum;

    always_comb begin
        cleared = field_q;
        found   = 1'b0;
        hit_cnt = '0;
        pts     = '0;
        // Grade on the pre-shift field so a hit note is never also counted as a miss.
        for (int unsigned l = 0; l < LANES; l++) begin
            found = 1'b0;
            for (int unsigned k = 0; k < HIT_WIN; k++) begin
                if (bus.key_hit[l] && !found && cleared[(ROWS-1-k)*LANES + l]) begin
                    cleared[(ROWS-1-k)*LANES + l] = 1'b0;
                    found   = 1'b1;
                    hit_cnt = hit_cnt + HW'(1);
                    pts     = pts + ((k == 0) ? HW'(2) : HW'(1));
                end
            end
        end

        row_in   = (addr_q < END_ADDR) ? nxt_q : '0;
        shifted  = {cleared[FW-LANES-1:0], row_in};
        lost     = bus.tick ? cleared[FW-1 -: LANES] : '0;
        lost_cnt = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lost_cnt = lost_cnt + HW'(lost[l]);
        end

        score_sum = {1'b0, score_q} + (SCORE_W+1)'(pts);
        combo_sum = {1'b0, combo_q} + (CNT_W+1)'(hit_cnt);
        miss_sum  = {1'b0, miss_q} + (CNT_W+1)'(lost_cnt);
    end

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        addr_d  = addr_q;
        score_d = score_q;
        combo_d = combo_q;
        miss_d  = miss_q;

        case (state_q)
            S_PREFETCH: state_d = S_RUN;
            S_PAUSE: begin
                if (!bus.pause) state_d = S_RUN;
            end
            S_RUN: begin
                field_d = bus.tick ? shifted : cleared;
                if (bus.tick && (addr_q < END_ADDR)) addr_d = addr_q + ADDR_W'(1);
                score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                miss_d  = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
                if (lost_cnt != '0)      combo_d = '0;
                else if (combo_sum[CNT_W]) combo_d = '1;
                else                     combo_d = combo_sum[CNT_W-1:0];
                if (bus.tick && (addr_d == END_ADDR) && (field_d == '0)) state_d = S_DONE;
                else if (bus.pause)                                       state_d = S_PAUSE;
            end
            default: ;
        endcase

        if (bus.start) begin
            state_d = S_PREFETCH;
            field_d = '0;
            addr_d  = '0;
            score_d = '0;
            combo_d = '0;
            miss_d  = '0;
        end
    end

    always_comb begin
        code_d = 2'd0;
        case (state_d)
            S_RUN:   code_d = 2'd1;
            S_PAUSE: code_d = 2'd2;
            S_DONE:  code_d = 2'd3;
            default: code_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            field_q <= '0;
            addr_q  <= '0;
            nxt_q   <= '0;
            score_q <= '0;
            combo_q <= '0;
            miss_q  <= '0;
            code_q  <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            addr_q  <= addr_d;
            nxt_q   <= bus.chart_data;
            score_q <= score_d;
            combo_q <= combo_d;
            miss_q  <= miss_d;
            code_q  <= code_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    assign bus.chart_addr = addr_q;
    assign bus.field      = field_q;
    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.misses     = miss_q;
    assign bus.state      = code_q;
    assign bus.done       = done_q;
endmodule

// File: doc/note_lane_engine.md
Name: note_lane_engine

Overview:
Parametrised successor to the ROM-driven falling-block manager. Scrolls chart rows from a synchronous chart ROM through a LANES x ROWS playfield, grades key hits inside a configurable hit window, and keeps score, combo and miss counters. Runs entirely on the system clock, with a scroll-tick enable instead of a separate refresh clock. Sits between the chart ROM and the display/score path.

Parameters:
LANES, 4, number of note lanes (key inputs and ROM data width)
ROWS, 16, playfield depth; row 0 is the top row, row ROWS-1 is the judgement row
ADDR_W, 16, chart ROM address width
CHART_LEN, 1024, number of chart rows played (addresses 0..CHART_LEN-1)
HIT_WIN, 2, number of bottom rows that accept hits (1..ROWS)
SCORE_W, 32, score counter width
CNT_W, 16, combo and miss counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle scroll enable; at least 2 clk cycles apart
start  in  1  one-cycle pulse; (re)starts the chart
pause  in  1  level; high holds the game
key_hit  in  LANES  one-cycle pulse per lane, already debounced and edge-detected
chart_addr  out  ADDR_W  chart ROM address
chart_data  in  LANES  ROM row data, valid 1 clk after chart_addr
field  out  ROWS*LANES  playfield; bit [r*LANES+l] = note at row r, lane l
score  out  SCORE_W  accumulated score
combo  out  CNT_W  current consecutive-hit count
misses  out  CNT_W  total missed notes
state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE
done  out  1  high while state==DONE

Behaviour:
- Reset: asynchronous and active-low; applies at any time, including mid-chart. All outputs and internal registers go to 0; state=IDLE.
- start in any state: clear field, score, combo and misses; set chart_addr=0; go to RUN after 1 clk (prefetch cycle). ROM latency is 1 clk, so the row for chart_addr is captured into prefetch buffer `nxt` on the clk after chart_addr changes.
- RUN, on tick:
  - Shift the field down one row.
  - The new row 0 is `nxt` if chart_addr < CHART_LEN, else all zeros.
  - Increment chart_addr, saturating at CHART_LEN.
- Miss: each note shifted out of row ROWS-1 on a tick does the following:
  - misses += popcount, saturating.
  - combo <= 0.
- Hit, in RUN on any clk: for each lane l with key_hit[l] set, take the lowest occupied row r in lane l with r >= ROWS-HIT_WIN.
  - If such a row exists: clear that note, combo += 1 (saturating), score += 2 if r == ROWS-1 (perfect) else 1 (good). Score saturates at all-ones.
  - If no note is in the window: the key is ignored, with no penalty.
- Multiple lanes hit in the same clk: all are processed; score and combo add the sums.
- Hit and tick in the same clk: hits are evaluated on the pre-shift field, then the shift applies to the cleared field. A hit note is therefore never also counted as a miss.
- Miss priority: if a miss and a hit occur in the same clk, combo ends at 0.
- End of chart: when chart_addr == CHART_LEN and the field is all zero after a tick, go to DONE. In DONE, tick and key_hit are ignored and outputs hold until start or reset.
- Pause: pause=1 in RUN moves to PAUSE on the next clk; pause=0 in PAUSE returns to RUN. In PAUSE, tick and key_hit are ignored; field, counters and chart_addr hold.
- IDLE: tick, key_hit and pause are ignored.
- All outputs are registered; counters update 1 clk after the causing event.

Test Plan:
- Reset mid-RUN with a non-zero field and score=7 -> all outputs 0 on the same cycle, state=IDLE, and they stay there until start.
- ROM rows 0001,0010,0100,1000, start, 16 ticks -> field row 15 = 0001 after the 16th tick; chart_addr = 16.
- Note in lane 0 at row 15; key_hit[0] -> score +2, combo 1, note cleared. Note at row 14 (HIT_WIN=2), key_hit -> score +1. Note at row 13 -> key ignored, score unchanged.
- Unhit note leaves row 15 on a tick with combo=5 -> misses=1, combo=0. Hit on lane 1 at row 15 with a tick in the same clk -> score +2, misses unchanged.
- All 4 lanes hit simultaneously at row 15 -> score +8, combo +4. Pause asserted for 10 ticks -> field, score and chart_addr unchanged; after release, scrolling resumes.
- CHART_LEN=4 -> after 4 rows are loaded and ROWS further ticks clear the field, state=DONE and done=1. A later start returns to RUN with counters cleared.
